// File: rtl/cve2_csr_bank_pkg.sv
// rtl/cve2_csr_bank_pkg.sv - operation/stage enums and the masked candidate-bit helper
package cve2_csr_bank_pkg;

  typedef enum logic [1:0] {
    CSR_NONE  = 2'd0,
    CSR_WRITE = 2'd1,
    CSR_SET   = 2'd2,
    CSR_CLEAR = 2'd3
  } csr_op_e;

  typedef enum logic {
    STAGE_IDLE   = 1'b0,
    STAGE_STAGED = 1'b1
  } csr_stage_e;

  // One bit of the candidate value: CSRRW/CSRRS/CSRRC result, kept at cur where the mask is 0.
  // Working per bit keeps the helper independent of the register width.
  function automatic logic csr_next_bit(csr_op_e op, logic cur, logic wd, logic msk);
    logic raw;
    case (op)
      CSR_WRITE: raw = wd;
      CSR_SET:   raw = cur | wd;
      CSR_CLEAR: raw = cur & ~wd;
      default:   raw = cur;
    endcase
    return msk ? raw : cur;
  endfunction

endpackage

// File: rtl/cve2_csr_bank_entry.sv
// rtl/cve2_csr_bank_entry.sv - one register with its sticky lock and optional inverted shadow
module cve2_csr_bank_entry #(
  parameter int               Width      = 32,
  parameter logic [Width-1:0] ResetValue = '0,
  parameter logic             ShadowCopy = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [Width-1:0] wval,
  input  logic             lock_set,
  output logic [Width-1:0] value,
  output logic             locked,
  output logic             mismatch
);

  // Committed register value
  always_ff @(posedge clk) begin
    if (rst) begin
      value <= ResetValue;
    end else if (we) begin
      value <= wval;
    end
  end

  // Lock is sticky until reset
  always_ff @(posedge clk) begin
    if (rst) begin
      locked <= 1'b0;
    end else if (lock_set) begin
      locked <= 1'b1;
    end
  end

  if (ShadowCopy) begin : g_shadow
    logic [Width-1:0] shadow;

    // Shadow holds the inverse of every committed value
    always_ff @(posedge clk) begin
      if (rst) begin
        shadow <= ~ResetValue;
      end else if (we) begin
        shadow <= ~wval;
      end
    end

    assign mismatch = (value != ~shadow);
  end else begin : g_no_shadow
    assign mismatch = 1'b0;
  end

endmodule

// File: rtl/cve2_csr_bank.sv
// rtl/cve2_csr_bank.sv - CSR bank top: decode, two-phase commit FSM, error flags
module cve2_csr_bank
  import cve2_csr_bank_pkg::*;
#(
  parameter int                         Width         = 32,
  parameter int                         NumRegs       = 4,
  parameter int                         AddrW         = $clog2(NumRegs),
  parameter logic [NumRegs*Width-1:0]   ResetValues   = '0,
  parameter logic [NumRegs*Width-1:0]   WriteMask     = '1,
  parameter logic                       ShadowCopy    = 1'b0,
  parameter logic                       TwoPhaseWrite = 1'b0
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     req_i,
  input  logic [1:0]               op_i,
  input  logic [AddrW-1:0]         addr_i,
  input  logic [Width-1:0]         wdata_i,
  input  logic                     lock_i,
  output logic [Width-1:0]         rdata_o,
  output logic [NumRegs*Width-1:0] regs_o,
  output logic                     commit_o,
  output logic                     staged_o,
  output logic                     err_update_o,
  output logic                     err_storage_o
);

  csr_op_e          op;
  logic [Width-1:0] vals [NumRegs];
  logic [NumRegs-1:0] locked;
  logic [NumRegs-1:0] mismatch;
  logic [Width-1:0] cur;
  logic [Width-1:0] cur_mask;
  logic [Width-1:0] cand;
  logic             cur_locked;
  logic             addr_ok;
  logic             lock_req;
  logic             active;
  logic             valid;
  logic             reject;
  logic             write_en;
  csr_stage_e       state;
  logic [Width-1:0] stage_val;
  logic [AddrW-1:0] stage_addr;

  assign op = csr_op_e'(op_i);

  // Select the addressed register; addresses beyond NumRegs match nothing and read as zero
  always_comb begin
    cur        = '0;
    cur_mask   = '0;
    cur_locked = 1'b0;
    addr_ok    = 1'b0;
    for (int i = 0; i < NumRegs; i++) begin
      if (addr_i == AddrW'(i)) begin
        cur        = vals[i];
        cur_mask   = WriteMask[i*Width +: Width];
        cur_locked = locked[i];
        addr_ok    = 1'b1;
      end
    end
  end

  // Masked candidate value for the requested operation
  always_comb begin
    cand = '0;
    for (int b = 0; b < Width; b++) begin
      cand[b] = csr_next_bit(op, cur[b], wdata_i[b], cur_mask[b]);
    end
  end

  assign rdata_o  = cur;
  assign lock_req = req_i && lock_i;
  assign active   = req_i && !lock_i && (op != CSR_NONE);
  assign valid    = active && addr_ok && !cur_locked;
  assign reject   = active && !valid;

  // Commit strobe: any valid request, or in two-phase mode only a matching second phase
  always_comb begin
    write_en = valid;
    if (TwoPhaseWrite) begin
      write_en = valid && (state == STAGE_STAGED) && (addr_i == stage_addr) && (cand == stage_val);
    end
  end

  // Two-phase stage FSM with registered commit/staged/update-error outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= STAGE_IDLE;
      stage_val    <= '0;
      stage_addr   <= '0;
      staged_o     <= 1'b0;
      commit_o     <= 1'b0;
      err_update_o <= 1'b0;
    end else begin
      commit_o     <= write_en;
      err_update_o <= reject;
      if (TwoPhaseWrite) begin
        case (state)
          STAGE_IDLE: begin
            if (valid) begin
              stage_val  <= cand;
              stage_addr <= addr_i;
              state      <= STAGE_STAGED;
              staged_o   <= 1'b1;
            end
          end
          STAGE_STAGED: begin
            if (lock_req && (addr_i == stage_addr)) begin
              state        <= STAGE_IDLE;
              staged_o     <= 1'b0;
              err_update_o <= 1'b1;
            end else if (valid) begin
              if (addr_i == stage_addr) begin
                state        <= STAGE_IDLE;
                staged_o     <= 1'b0;
                err_update_o <= (cand != stage_val);
              end else begin
                stage_val    <= cand;
                stage_addr   <= addr_i;
                err_update_o <= 1'b1;
              end
            end
          end
          default: begin
            state    <= STAGE_IDLE;
            staged_o <= 1'b0;
          end
        endcase
      end
    end
  end

  // Sticky storage error from pre-edge register/shadow comparison
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_storage_o <= 1'b0;
    end else if (ShadowCopy && (|mismatch)) begin
      err_storage_o <= 1'b1;
    end
  end

  for (genvar i = 0; i < NumRegs; i++) begin : g_entry
    cve2_csr_bank_entry #(
      .Width      (Width),
      .ResetValue (ResetValues[i*Width +: Width]),
      .ShadowCopy (ShadowCopy)
    ) u_entry (
      .clk      (clk_i),
      .rst      (rst_i),
      .we       (write_en && (addr_i == AddrW'(i))),
      .wval     (cand),
      .lock_set (lock_req && (addr_i == AddrW'(i))),
      .value    (vals[i]),
      .locked   (locked[i]),
      .mismatch (mismatch[i])
    );

    assign regs_o[i*Width +: Width] = vals[i];

    // Read-only bits never leave their reset value
    assert property (@(posedge clk_i) disable iff (rst_i)
      ((vals[i] & ~WriteMask[i*Width +: Width]) ==
       (ResetValues[i*Width +: Width] & ~WriteMask[i*Width +: Width])));
  end

  // Control inputs are known whenever the bank is running
  assert property (@(posedge clk_i) disable iff (rst_i) !$isunknown({req_i, op_i, lock_i}));

endmodule
